// File: rtl/priority_intr_ctrl_if.sv
// Peripheral-bus interface for the priority interrupt controller.
// The CPU-side peripheral controller is the master; the interrupt controller is the slave.
interface priority_intr_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ce;
    logic                  rw;
    logic [2:0]            address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output ce,
        output rw,
        output address,
        output data_in,
        input  data_out
    );

    modport slave (
        input  ce,
        input  rw,
        input  address,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/priority_intr_ctrl.sv
// Parametrised priority interrupt controller.
// Collects IRQ_COUNT request lines (per-line edge/level mode and mask), raises a single
// intr to the CPU and holds the winning line ID until software acknowledges it.
// Fixed priority: the lowest enabled pending line wins.
module priority_intr_ctrl #(
    parameter int         IRQ_COUNT    = 8,
    parameter int         DATA_WIDTH   = 32,
    parameter logic [2:0] IRQ_ID_ADDR  = 3'd0,
    parameter logic [2:0] MASK_ADDR    = 3'd1,
    parameter logic [2:0] INT_ACK_ADDR = 3'd2,
    parameter logic [2:0] PENDING_ADDR = 3'd3,
    parameter logic [2:0] MODE_ADDR    = 3'd4
) (
    input  logic                 clk,
    input  logic                 rst,
    priority_intr_ctrl_if.slave  bus,
    input  logic [IRQ_COUNT-1:0] irq,
    output logic                 intr
);

    localparam int ID_W = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t               state_q, state_d;
    logic [IRQ_COUNT-1:0] irq_q, irq_d;
    logic [IRQ_COUNT-1:0] mask_q, mask_d;
    logic [IRQ_COUNT-1:0] mode_q, mode_d;
    logic [IRQ_COUNT-1:0] pending_q, pending_d;
    logic [ID_W-1:0]      irq_id_q, irq_id_d;

    logic                 wr_en;
    logic                 rd_en;
    logic [IRQ_COUNT-1:0] wr_lines;
    logic [IRQ_COUNT-1:0] rise;
    logic [IRQ_COUNT-1:0] active;
    logic [IRQ_COUNT-1:0] clr;
    logic [ID_W-1:0]      win_id;
    logic                 ack_hit;
    logic                 unused_data_in;

    assign wr_en          = bus.ce & bus.rw;
    assign rd_en          = bus.ce & ~bus.rw;
    assign wr_lines       = bus.data_in[IRQ_COUNT-1:0];
    assign rise           = irq & ~irq_q;
    assign active         = pending_q & mask_q;
    assign irq_d          = irq;
    assign unused_data_in = ^bus.data_in;

    // An acknowledge only counts while waiting and only if it names the latched line
    always_comb begin
        ack_hit = 1'b0;
        if (wr_en && (bus.address == INT_ACK_ADDR) && (state_q == WAIT_ACK) &&
            (bus.data_in[ID_W-1:0] == irq_id_q)) begin
            ack_hit = 1'b1;
        end
    end

    // Mask and mode registers; bits above IRQ_COUNT simply never get stored
    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (wr_en && (bus.address == MASK_ADDR)) begin
            mask_d = wr_lines;
        end
        if (wr_en && (bus.address == MODE_ADDR)) begin
            mode_d = wr_lines;
        end
    end

    // Pending bits: level lines mirror irq_q, edge lines latch rising edges (set beats clear)
    always_comb begin
        clr       = '0;
        pending_d = pending_q;
        if (wr_en && (bus.address == PENDING_ADDR)) begin
            clr = wr_lines;
        end
        for (int i = 0; i < IRQ_COUNT; i++) begin
            if (ack_hit && (ID_W'(i) == irq_id_q)) begin
                clr[i] = 1'b1;
            end
            if (!mode_q[i]) begin
                pending_d[i] = irq_q[i];
            end else begin
                pending_d[i] = (pending_q[i] & ~clr[i]) | rise[i];
            end
            if (mode_d[i] && !mode_q[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Fixed-priority encoder: scanning downwards leaves the lowest active index
    always_comb begin
        win_id = '0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // Next-state and output logic; IRQ ID only changes when leaving IDLE
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        intr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|active) begin
                    irq_id_d = win_id;
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                intr = 1'b1;
                if (ack_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational register read port; idle bus reads as zero
    always_comb begin
        bus.data_out = '0;
        if (rd_en) begin
            case (bus.address)
                IRQ_ID_ADDR:  bus.data_out = DATA_WIDTH'(irq_id_q);
                MASK_ADDR:    bus.data_out = DATA_WIDTH'(mask_q);
                PENDING_ADDR: bus.data_out = DATA_WIDTH'(pending_q);
                MODE_ADDR:    bus.data_out = DATA_WIDTH'(mode_q);
                default:      bus.data_out = '0;
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            irq_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            irq_id_q  <= irq_id_d;
        end
    end

endmodule

// File: tb/tb_priority_intr_ctrl.sv
// Directed testbench for priority_intr_ctrl: an 8-line instance for the main scenarios
// and a 3-line instance for register truncation and reset-while-waiting.
module tb_priority_intr_ctrl;

    localparam logic [2:0] A_ID      = 3'd0;
    localparam logic [2:0] A_MASK    = 3'd1;
    localparam logic [2:0] A_ACK     = 3'd2;
    localparam logic [2:0] A_PENDING = 3'd3;
    localparam logic [2:0] A_MODE    = 3'd4;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] irq8;
    logic [2:0] irq3;
    logic       intr8;
    logic       intr3;

    int   vectors;
    int   miscompares;
    exp_t sb_q[$];

    priority_intr_ctrl_if #(.DATA_WIDTH(32)) bus8 ();
    priority_intr_ctrl_if #(.DATA_WIDTH(32)) bus3 ();

    priority_intr_ctrl #(.IRQ_COUNT(8), .DATA_WIDTH(32)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus8),
        .irq  (irq8),
        .intr (intr8)
    );

    priority_intr_ctrl #(.IRQ_COUNT(3), .DATA_WIDTH(32)) dut3 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus3),
        .irq  (irq3),
        .intr (intr3)
    );

    // Free-running clock
    always #20 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: sequence did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] v8, input logic [2:0] v3);
        irq8 = v8;
        irq3 = v3;
    endtask

    task automatic bus_write(input bit sel3, input logic [2:0] a, input logic [31:0] d);
        if (sel3) begin
            bus3.ce = 1'b1; bus3.rw = 1'b1; bus3.address = a; bus3.data_in = d;
        end else begin
            bus8.ce = 1'b1; bus8.rw = 1'b1; bus8.address = a; bus8.data_in = d;
        end
        tick();
        bus8.ce = 1'b0; bus8.rw = 1'b0;
        bus3.ce = 1'b0; bus3.rw = 1'b0;
    endtask

    task automatic bus_read(input bit sel3, input logic [2:0] a, output logic [31:0] d);
        if (sel3) begin
            bus3.ce = 1'b1; bus3.rw = 1'b0; bus3.address = a;
        end else begin
            bus8.ce = 1'b1; bus8.rw = 1'b0; bus8.address = a;
        end
        #1;
        d = sel3 ? bus3.data_out : bus8.data_out;
        bus8.ce = 1'b0;
        bus3.ce = 1'b0;
    endtask

    task automatic push_expect(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: observed 0x%0h required an expectation", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.val) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", e.tag, observed, e.val);
            end
        end
    endtask

    task automatic check_intr(input bit sel3, input string tag, input logic exp_v);
        push_expect(tag, {31'b0, exp_v});
        checkOutput({31'b0, (sel3 ? intr3 : intr8)});
    endtask

    task automatic check_reg(input bit sel3, input string tag, input logic [2:0] a,
                             input logic [31:0] exp_v);
        logic [31:0] d;
        push_expect(tag, exp_v);
        bus_read(sel3, a, d);
        checkOutput(d);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        vectors = 0;
        miscompares = 0;
        applyStimulus(8'h00, 3'b000);
        bus8.ce = 1'b0; bus8.rw = 1'b0; bus8.address = 3'd0; bus8.data_in = '0;
        bus3.ce = 1'b0; bus3.rw = 1'b0; bus3.address = 3'd0; bus3.data_in = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state: everything reads zero, no interrupt
        check_intr(0, "reset_intr", 1'b0);
        for (int a = 0; a < 8; a++) begin
            check_reg(0, $sformatf("reset_reg%0d", a), 3'(a), 32'h0);
        end

        // Level mode (reset default), masked: pulse irq[3] shows in PENDING only
        applyStimulus(8'h08, 3'b000);
        tick();
        applyStimulus(8'h00, 3'b000);
        tick();
        check_reg(0, "masked_pending", A_PENDING, 32'h08);
        check_intr(0, "masked_no_intr", 1'b0);
        tick();
        tick();
        check_intr(0, "masked_no_intr_later", 1'b0);

        // All edge, all enabled; lines 5 and 2 together, lowest wins
        bus_write(0, A_MODE, 32'hFF);
        bus_write(0, A_MASK, 32'hFF);
        applyStimulus(8'h24, 3'b000);
        tick();
        applyStimulus(8'h00, 3'b000);
        check_intr(0, "edge_latency_1", 1'b0);
        tick();
        check_intr(0, "edge_latency_2", 1'b1);
        check_reg(0, "id_first", A_ID, 32'd2);
        check_reg(0, "pending_both", A_PENDING, 32'h24);
        push_expect("idle_bus_zero", 32'h0);
        bus8.address = A_PENDING;
        #1;
        checkOutput(bus8.data_out);
        bus_write(0, A_ACK, 32'd2);
        check_intr(0, "ack2_low", 1'b0);
        check_reg(0, "ack2_pending", A_PENDING, 32'h20);
        tick();
        check_intr(0, "second_high", 1'b1);
        check_reg(0, "id_second", A_ID, 32'd5);
        bus_write(0, A_ACK, 32'd5);
        check_intr(0, "ack5_low", 1'b0);
        tick();
        check_intr(0, "ack5_stays_low", 1'b0);
        check_reg(0, "ack5_pending", A_PENDING, 32'h0);

        // Wrong-ID acknowledge is ignored
        applyStimulus(8'h02, 3'b000);
        tick();
        applyStimulus(8'h00, 3'b000);
        tick();
        check_intr(0, "line1_high", 1'b1);
        bus_write(0, A_ACK, 32'd4);
        check_intr(0, "wrong_ack_high", 1'b1);
        check_reg(0, "wrong_ack_id", A_ID, 32'd1);
        bus_write(0, A_ACK, 32'd1);
        check_intr(0, "right_ack_low", 1'b0);
        tick();
        check_intr(0, "right_ack_stays", 1'b0);

        // Level line 0 held high: 3-edge latency, re-raises after ACK
        bus_write(0, A_MODE, 32'hFE);
        applyStimulus(8'h01, 3'b000);
        tick();
        check_intr(0, "level_lat_k", 1'b0);
        tick();
        check_intr(0, "level_lat_k1", 1'b0);
        tick();
        check_intr(0, "level_lat_k2", 1'b1);
        check_reg(0, "level_id", A_ID, 32'd0);
        bus_write(0, A_ACK, 32'd0);
        check_intr(0, "level_ack_low", 1'b0);
        tick();
        check_intr(0, "level_rerise", 1'b1);
        applyStimulus(8'h00, 3'b000);
        tick();
        tick();
        bus_write(0, A_ACK, 32'd0);
        check_intr(0, "level_drop_ack", 1'b0);
        tick();
        check_intr(0, "level_drop_stays1", 1'b0);
        tick();
        check_intr(0, "level_drop_stays2", 1'b0);

        // Masked edge line 7 latches, then write-1-to-clear
        bus_write(0, A_MASK, 32'h7F);
        applyStimulus(8'h80, 3'b000);
        tick();
        applyStimulus(8'h00, 3'b000);
        tick();
        check_reg(0, "w1c_before", A_PENDING, 32'h80);
        check_intr(0, "w1c_masked", 1'b0);
        bus_write(0, A_PENDING, 32'h80);
        check_reg(0, "w1c_after", A_PENDING, 32'h0);

        // Edge line 6: ACK coincides with a new rising edge, set wins
        bus_write(0, A_MODE, 32'hFF);
        bus_write(0, A_MASK, 32'hFF);
        applyStimulus(8'h40, 3'b000);
        tick();
        applyStimulus(8'h00, 3'b000);
        tick();
        check_intr(0, "line6_high", 1'b1);
        applyStimulus(8'h40, 3'b000);
        bus_write(0, A_ACK, 32'd6);
        applyStimulus(8'h00, 3'b000);
        check_intr(0, "line6_ack_low", 1'b0);
        check_reg(0, "line6_pending_kept", A_PENDING, 32'h40);
        tick();
        check_intr(0, "line6_reassert", 1'b1);
        check_reg(0, "line6_id", A_ID, 32'd6);
        bus_write(0, A_ACK, 32'd6);
        tick();
        check_intr(0, "line6_done", 1'b0);
        check_reg(0, "line6_cleared", A_PENDING, 32'h0);

        // Three-line instance: truncation of wide writes, then reset while waiting
        bus_write(1, A_MASK, 32'hFFFFFFFF);
        check_reg(1, "n3_mask", A_MASK, 32'h7);
        bus_write(1, A_MODE, 32'hFFFFFFFF);
        check_reg(1, "n3_mode", A_MODE, 32'h7);
        applyStimulus(8'h00, 3'b010);
        tick();
        applyStimulus(8'h00, 3'b000);
        tick();
        check_intr(1, "n3_high", 1'b1);
        check_reg(1, "n3_id", A_ID, 32'd1);
        rst = 1'b1;
        tick();
        check_intr(1, "n3_reset_intr", 1'b0);
        check_reg(1, "n3_reset_id", A_ID, 32'h0);
        check_reg(1, "n3_reset_mask", A_MASK, 32'h0);
        check_reg(1, "n3_reset_pending", A_PENDING, 32'h0);
        check_reg(1, "n3_reset_mode", A_MODE, 32'h0);
        rst = 1'b0;
        tick();
        check_intr(1, "n3_after_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
